// File: rtl/fp_dist_match.sv
// fp_dist_match
//   Per-pixel Gaussian match stage of the GMM foreground detector. Takes the
//   multiplier's stream of squared normalised distances (K consecutive fp32
//   products per pixel), compares each against a per-component fp32
//   threshold with IEEE-754 strict less-than ordering, and emits one result
//   per pixel: match mask, any-match (background) flag, first-match index
//   and a NaN-seen flag.
//
// Parameters
//   K      Gaussian components per pixel (2..8)
//   IDX_W  width of the component index fields
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   snk_valid/snk_ready   product beat handshake (one component per beat)
//   snk_data              fp32 product d^2
//   snk_thresh            fp32 threshold for the same component
//   src_valid/src_ready   per-pixel result handshake
//   src_match             bit k set when component k matched
//   src_any               at least one component matched
//   src_first             lowest matching index, 0 when none matched
//   src_nan               a NaN operand was seen in the group
//
// Configuration
//   FP_DIST_MATCH_NAN_CHECK_EN  when defined, NaN operands force a miss and
//                               raise src_nan; otherwise NaN bit patterns are
//                               ordered by raw bits and src_nan is tied to 0.

module fp_dist_match #(
    parameter int K     = 3,
    parameter int IDX_W = $clog2(K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             snk_valid,
    input  logic [31:0]      snk_data,
    input  logic [31:0]      snk_thresh,
    output logic             snk_ready,
    input  logic             src_ready,
    output logic             src_valid,
    output logic [K-1:0]     src_match,
    output logic             src_any,
    output logic [IDX_W-1:0] src_first,
    output logic             src_nan
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

    // Strict IEEE-754 a < b on the sign/magnitude encoding. +0 and -0 are
    // equal; denormals order naturally by their bit patterns.
    function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
        logic both_zero;
        logic lt;
        both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
        case ({a[31], b[31]})
            2'b00:   lt = a[30:0] < b[30:0];
            2'b10:   lt = !both_zero;
            2'b01:   lt = 1'b0;
            default: lt = a[30:0] > b[30:0];
        endcase
        return lt;
    endfunction

    logic [IDX_W-1:0] cnt;
    logic [K-2:0]     partial_mask;
    logic             beat_match;
    logic             accept;
    logic             last_beat;
    logic [K-1:0]     full_match;
    logic [IDX_W-1:0] full_first;

    assign last_beat = (cnt == LAST);

    // Only the final beat can be held off, and only while the previous
    // result has not been taken. The src_ready term keeps a full-rate
    // stream bubble-free.
    assign snk_ready = !last_beat || !src_valid || src_ready;
    assign accept    = snk_valid && snk_ready;

    assign full_match = {beat_match, partial_mask};

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        full_first = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (full_match[i]) full_first = IDX_W'(i);
        end
    end

`ifdef FP_DIST_MATCH_NAN_CHECK_EN
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    logic beat_nan;
    logic partial_nan;
    logic nan_q;

    assign beat_nan   = is_nan(snk_data) || is_nan(snk_thresh);
    assign beat_match = !beat_nan && fp_lt(snk_data, snk_thresh);
    assign src_nan    = nan_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            partial_nan <= 1'b0;
            nan_q       <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                nan_q       <= partial_nan || beat_nan;
                partial_nan <= 1'b0;
            end else begin
                partial_nan <= partial_nan || beat_nan;
            end
        end
    end
`else
    assign beat_match = fp_lt(snk_data, snk_thresh);
    assign src_nan    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the later assignment in program order wins
    // when a handshake and a reload fall in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            partial_mask <= '0;
            src_valid    <= 1'b0;
            src_match    <= '0;
            src_any      <= 1'b0;
            src_first    <= '0;
        end else begin
            if (src_valid && src_ready) src_valid <= 1'b0;

            if (accept) begin
                if (last_beat) begin
                    src_match    <= full_match;
                    src_any      <= |full_match;
                    src_first    <= full_first;
                    src_valid    <= 1'b1;
                    cnt          <= '0;
                    partial_mask <= '0;
                end else begin
                    for (int i = 0; i < K - 1; i++) begin
                        if (cnt == IDX_W'(i)) partial_mask[i] <= beat_match;
                    end
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_dist_match.sv
// Self-checking bench for fp_dist_match (K=3). Directed steps follow the
// block's intended use cases; a randomized phase with random downstream
// backpressure is checked against a behavioural model that orders fp32
// values by mapping them onto signed integers.

module tb_fp_dist_match;

    localparam int K     = 3;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             snk_valid;
    logic [31:0]      snk_data;
    logic [31:0]      snk_thresh;
    logic             snk_ready;
    logic             src_ready;
    logic             src_valid;
    logic [K-1:0]     src_match;
    logic             src_any;
    logic [IDX_W-1:0] src_first;
    logic             src_nan;

    fp_dist_match #(.K(K), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .snk_valid  (snk_valid),
        .snk_data   (snk_data),
        .snk_thresh (snk_thresh),
        .snk_ready  (snk_ready),
        .src_ready  (src_ready),
        .src_valid  (src_valid),
        .src_match  (src_match),
        .src_any    (src_any),
        .src_first  (src_first),
        .src_nan    (src_nan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [K-1:0] mask;
        logic         any;
        logic [1:0]   first;
        logic         nan;
    } res_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    res_t exp_q[$];
    int   res_times[$];
    logic rand_ready = 1'b0;

    // model state for the group being assembled
    int           m_cnt = 0;
    logic [K-1:0] m_mask = '0;
    logic         m_nan = 1'b0;

`ifdef FP_DIST_MATCH_NAN_CHECK_EN
    localparam logic NAN_EN = 1'b1;
`else
    localparam logic NAN_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // fp32 values placed on the real number line as signed integers:
    // magnitude bits grow monotonically with value, sign flips the axis,
    // and both zeros land on 0.
    function automatic longint fp_key(input logic [31:0] x);
        longint mag;
        mag = longint'(x[30:0]);
        return x[31] ? -mag : mag;
    endfunction

    function automatic logic ref_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    task automatic model_beat(input logic [31:0] d, input logic [31:0] t);
        logic m;
        logic n;
        res_t r;
        n = NAN_EN && (ref_nan(d) || ref_nan(t));
        m = !n && (fp_key(d) < fp_key(t));
        m_mask[m_cnt] = m;
        m_nan = m_nan || n;
        if (m_cnt == K - 1) begin
            r.mask  = m_mask;
            r.any   = (m_mask != 0);
            r.first = 2'd0;
            for (int i = K - 1; i >= 0; i--) if (m_mask[i]) r.first = 2'(i);
            r.nan   = m_nan;
            exp_q.push_back(r);
            m_cnt  = 0;
            m_mask = '0;
            m_nan  = 1'b0;
        end else begin
            m_cnt++;
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rand_ready) src_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor and model update, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_cnt  = 0;
            m_mask = '0;
            m_nan  = 1'b0;
        end else begin
            if (src_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(src_valid), 32'd0);
                end else begin
                    check("src_match", 32'(src_match), 32'(exp_q[0].mask));
                    check("src_any",   32'(src_any),   32'(exp_q[0].any));
                    check("src_first", 32'(src_first), 32'(exp_q[0].first));
                    check("src_nan",   32'(src_nan),   32'(exp_q[0].nan));
                    if (src_ready) begin
                        void'(exp_q.pop_front());
                        res_times.push_back(cyc);
                    end
                end
            end
            if (snk_valid && snk_ready) model_beat(snk_data, snk_thresh);
        end
    end

    // Present one beat (caller is just after a posedge), wait for it to be
    // taken, return the negedge cycle it was seen and how many negedges it took.
    task automatic send(input logic [31:0] d, input logic [31:0] t,
                        output int acc_cyc, output int waits);
        snk_valid  = 1'b1;
        snk_data   = d;
        snk_thresh = t;
        waits      = 0;
        acc_cyc    = -1;
        while (acc_cyc < 0) begin
            @(negedge clk);
            waits++;
            if (snk_ready) acc_cyc = cyc;
            else if (waits > 200) begin
                check("send_timeout", 32'd0, 32'd1);
                acc_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        snk_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        src_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || src_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_fp(input logic [31:0] near);
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = $urandom;
            1: v = near + 32'($urandom_range(0, 4)) - 32'd2;
            2: v = {1'($urandom_range(0, 1)), 31'd0};
            3: v = 32'h3F80_0000 + 32'($urandom_range(0, 32'h01FF_FFFF));
            default: v = {1'($urandom_range(0, 1)), 31'(near[30:0])};
        endcase
        return v;
    endfunction

    localparam logic [31:0] F_1     = 32'h3F80_0000;
    localparam logic [31:0] F_4     = 32'h4080_0000;
    localparam logic [31:0] F_9     = 32'h4110_0000;
    localparam logic [31:0] F_6_25  = 32'h40C8_0000;
    localparam logic [31:0] F_100   = 32'h42C8_0000;
    localparam logic [31:0] F_P0    = 32'h0000_0000;
    localparam logic [31:0] F_N0    = 32'h8000_0000;
    localparam logic [31:0] F_M1    = 32'hBF80_0000;
    localparam logic [31:0] F_HALF  = 32'h3F00_0000;
    localparam logic [31:0] F_QNAN  = 32'h7FC0_0000;

    initial begin
        int a;
        int w;
        int t0;
        logic [31:0] th;

        rst        = 1'b1;
        snk_valid  = 1'b0;
        snk_data   = '0;
        snk_thresh = '0;
        src_ready  = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_src_valid", 32'(src_valid), 32'd0);
        check("rst_src_match", 32'(src_match), 32'd0);
        check("rst_src_any",   32'(src_any),   32'd0);
        check("rst_src_first", 32'(src_first), 32'd0);
        check("rst_src_nan",   32'(src_nan),   32'd0);
        check("rst_snk_ready", 32'(snk_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1.0, 4.0, 9.0 vs 6.25: result one cycle after the final beat
        send(F_1, F_6_25, a, w);
        send(F_4, F_6_25, a, w);
        send(F_9, F_6_25, a, w);
        check("t1_valid_latency", 32'(src_valid), 32'd1);
        check("t1_match", 32'(src_match), 32'b011);
        check("t1_any",   32'(src_any),   32'd1);
        check("t1_first", 32'(src_first), 32'd0);
        drain();

        // No matches, then +0 vs -0 in the group
        send(F_100, F_6_25, a, w);
        send(F_100, F_6_25, a, w);
        send(F_100, F_6_25, a, w);
        check("t2_match", 32'(src_match), 32'd0);
        check("t2_any",   32'(src_any),   32'd0);
        check("t2_first", 32'(src_first), 32'd0);
        send(F_P0, F_N0, a, w);
        send(F_N0, F_P0, a, w);
        send(F_4, F_6_25, a, w);
        check("t2_zero_match", 32'(src_match), 32'b100);
        check("t2_zero_first", 32'(src_first), 32'd2);
        drain();

        // Backpressure: hold one result, next group's final beat stalls
        src_ready = 1'b0;
        send(F_100, F_6_25, a, w);
        send(F_1,   F_6_25, a, w);
        send(F_100, F_6_25, a, w);
        send(F_1,   F_6_25, a, w);
        check("t3_b0_no_stall", 32'(w), 32'd1);
        send(F_100, F_6_25, a, w);
        check("t3_b1_no_stall", 32'(w), 32'd1);
        snk_valid  = 1'b1;
        snk_data   = F_100;
        snk_thresh = F_6_25;
        @(negedge clk);
        check("t3_b2_stalled", 32'(snk_ready), 32'd0);
        check("t3_held_valid", 32'(src_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_b2_still_stalled", 32'(snk_ready), 32'd0);
        check("t3_held_match", 32'(src_match), 32'b010);
        @(posedge clk);
        #1;
        src_ready = 1'b1;
        @(negedge clk);
        check("t3_b2_released", 32'(snk_ready), 32'd1);
        @(posedge clk);
        #1;
        snk_valid = 1'b0;
        @(negedge clk);
        check("t3_no_bubble", 32'(src_valid), 32'd1);
        check("t3_new_match", 32'(src_match), 32'b001);
        drain();

        // Continuous stream of 4 pixels, results every K cycles
        res_times.delete();
        send(F_M1, F_HALF, t0, w);
        send(F_100, F_6_25, a, w);
        send(F_9, F_6_25, a, w);
        for (int p = 1; p < 4; p++) begin
            send(F_9, F_6_25, a, w);
            send(32'(F_1 + 32'(p)), F_6_25, a, w);
            send(F_HALF, F_M1, a, w);
        end
        drain();
        check("t4_result_count", 32'(res_times.size()), 32'd4);
        for (int p = 0; p < 4 && p < res_times.size(); p++)
            check("t4_result_time", 32'(res_times[p] - t0), 32'(3 * (p + 1)));

        // Reset mid-group discards the partial group
        send(F_1, F_6_25, a, w);
        send(F_1, F_6_25, a, w);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("t5_valid_in_rst", 32'(src_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(F_100, F_6_25, a, w);
        send(F_100, F_6_25, a, w);
        send(F_1,   F_6_25, a, w);
        check("t5_match", 32'(src_match), 32'b100);
        check("t5_first", 32'(src_first), 32'd2);
        drain();

        // NaN operand on component 1
        send(F_1,    F_6_25, a, w);
        send(F_QNAN, F_6_25, a, w);
        send(F_1,    F_6_25, a, w);
        check("t6_match", 32'(src_match), 32'b101);
        check("t6_nan",   32'(src_nan),   32'(NAN_EN));
        drain();

        // Randomized groups with random downstream backpressure
        rand_ready = 1'b1;
        for (int g = 0; g < 60; g++) begin
            for (int b = 0; b < K; b++) begin
                th = rand_fp(F_6_25);
                send(rand_fp(th), th, a, w);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        rand_ready = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_dist_match.md
Name: fp_dist_match

Overview:
- Sits directly downstream of the fp32 multiplier stage in the GMM foreground detector's subtract path.
- Consumes that stage's product stream: one squared normalised distance d² per Gaussian component, K consecutive products per pixel.
- Compares each product against a per-component fp32 threshold arriving alongside it, and assembles a per-pixel match result.
- Result carries a match mask, the first-match index and a background/foreground decision, and feeds the model-update and mask-output stages under valid/ready backpressure.

Parameters:
- K, 3, Gaussian components per pixel (products per group), 2..8.
- IDX_W, $clog2(K), width of the component index fields.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- snk_valid, input, 1, product and threshold valid.
- snk_data, input, 32, fp32 product d² (from multiplier src_data).
- snk_thresh, input, 32, fp32 threshold for the same component.
- snk_ready, output, 1, block accepts a sink beat this cycle.
- src_ready, input, 1, downstream accepts the result.
- src_valid, output, 1, per-pixel result valid.
- src_match, output, K, bit k set when component k matched.
- src_any, output, 1, at least one component matched (background).
- src_first, output, IDX_W, lowest index of a matching component; 0 when src_any=0.
- src_nan, output, 1, a NaN operand was seen in the group (see Optional Feature).

Behaviour:
- Reset: asynchronous, active-high. While rst=1 and after release:
  - src_valid=0, src_match=0, src_any=0, src_first=0, src_nan=0.
  - Group counter cnt=0, partial mask=0, partial nan flag=0.
- Reset mid-group discards the partial group. The first beat after reset is component 0.
- Accept rule: a sink beat transfers when snk_valid && snk_ready. The beat is component index cnt.
- snk_ready = (cnt != K-1) || !src_valid || src_ready. This is combinational from src_ready.
  - Non-final beats are never stalled.
  - The final beat stalls only while an unconsumed result is held.
- Compare (combinational on the accepted beat): match = fp_lt(snk_data, snk_thresh), strict less-than under IEEE-754 ordering.
  - Both signs non-negative: compare raw bits [30:0] unsigned.
  - Negative vs non-negative: negative is smaller.
  - Both negative: larger magnitude is smaller.
  - +0 and -0 compare equal, so 0 < 0 gives no match.
  - Denormals are compared by bit pattern, with no flush.
- On each accepted beat with cnt < K-1: partial_mask[cnt] <= match, then cnt <= cnt+1.
- On the accepted beat with cnt = K-1:
  - Output register loads src_match = {match, partial_mask[K-2:0]}.
  - src_any = |src_match.
  - src_first = priority encode of the lowest set bit.
  - src_valid <= 1; cnt <= 0; partial mask cleared.
- Latency: result valid one cycle after the final (K-th) beat is accepted.
- Output hold: src_valid and all src_* fields stay stable until src_valid && src_ready.
  - On that handshake, src_valid <= 0, unless a new final beat is accepted in the same cycle, in which case the register reloads and src_valid stays 1.
  - Full throughput: one pixel per K cycles, with no bubble when src_ready is held high.
- src_valid deasserting does not reset src_match etc.; those hold their last values.
- snk_valid low: no state change. Gaps between beats of a group are allowed.

Optional Feature:
- Macro: FP_DIST_MATCH_NAN_CHECK_EN.
- Defined:
  - An operand is NaN when exp=0xFF and mantissa!=0 (either input).
  - A NaN operand forces match=0 for that component.
  - It sets the partial nan flag, which ORs into src_nan at group completion.
  - +/-Inf compare normally.
- Undefined:
  - No NaN decode; NaN patterns compare by raw bits per the ordering above.
  - src_nan is tied to 0.

Test Plan:
- Reset release, K=3, src_ready=1; products 1.0, 4.0, 9.0 (0x3F800000, 0x40800000, 0x41100000) vs threshold 6.25 (0x40C80000) on back-to-back beats → one cycle after the third beat: src_valid=1, src_match=3'b011, src_any=1, src_first=0.
- Products all 100.0 vs threshold 6.25 → src_match=0, src_any=0, src_first=0. Then d²=+0 vs thresh=-0 → no match.
- src_ready=0 with one result held: the next group's beats 0 and 1 are accepted (snk_ready=1), beat 2 sees snk_ready=0 → raise src_ready → the same cycle completes the handoff and loads the new result; src_valid stays 1 with no bubble.
- Continuous stream of 4 pixels, src_ready=1 → 4 results at cycles 3, 6, 9, 12 after the first beat. Product -1.0 vs threshold 0.5 → match.
- rst pulsed after beat 1 of a group, then a fresh 3-beat group → result reflects only the new beats; src_valid low throughout reset.
- With FP_DIST_MATCH_NAN_CHECK_EN: beat 1 = 0x7FC00000 (NaN) vs 6.25, others 1.0 → src_match=3'b101, src_nan=1. Without the macro: src_match=3'b101, src_nan=0.
